rf_wb_arbiter: RTL

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter.
// Two writeback sources (ALU, load) share a single register-file write port.
// Grants are combinational and round-robin; the write port is registered, so
// a write appears one cycle after its transfer. Address-0 writes can be
// discarded (hardwired-zero register) and are counted in a saturating counter.
module rf_wb_arbiter #(
  parameter int NUM_REG = 6,
  parameter int BITS    = 32,
  parameter int ZERO_RO = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               v0_i,
  input  logic [NUM_REG-1:0] a0_i,
  input  logic [BITS-1:0]    d0_i,
  output logic               rdy0_o,
  input  logic               v1_i,
  input  logic [NUM_REG-1:0] a1_i,
  input  logic [BITS-1:0]    d1_i,
  output logic               rdy1_o,
  output logic               wen_o,
  output logic [NUM_REG-1:0] wa_o,
  output logic [BITS-1:0]    wd_o,
  output logic               prio_o,
  output logic [7:0]         drop_cnt_o
);

  localparam int NUM_LANES = 2;

  typedef struct packed {
    logic [NUM_REG-1:0] addr;
    logic [BITS-1:0]    data;
  } wb_req_t;

  logic [NUM_LANES-1:0] vld;
  logic [NUM_LANES-1:0] gnt;
  wb_req_t [NUM_LANES-1:0] req;
  wb_req_t              sel;
  logic                 xfer;
  logic                 gnt_idx;
  logic                 discard;

  logic               wen_q,  wen_d;
  logic [NUM_REG-1:0] wa_q,   wa_d;
  logic [BITS-1:0]    wd_q,   wd_d;
  logic               prio_q, prio_d;
  logic [7:0]         drop_q, drop_d;

  assign vld    = {v1_i, v0_i};
  assign req[0] = '{addr: a0_i, data: d0_i};
  assign req[1] = '{addr: a1_i, data: d1_i};

  // Round-robin grant: a lone requester wins; on contention prio_q wins.
  // Nothing is granted under stall or while reset is held.
  always_comb begin
    gnt = '0;
    if (rst_n && !stall_i) begin
      if (vld[0] && (!vld[1] || !prio_q)) gnt[0] = 1'b1;
      if (vld[1] && (!vld[0] ||  prio_q)) gnt[1] = 1'b1;
    end
  end

  assign rdy0_o  = gnt[0];
  assign rdy1_o  = gnt[1];
  assign xfer    = |(gnt & vld);
  assign gnt_idx = gnt[1];
  assign sel     = req[gnt_idx];
  assign discard = (ZERO_RO != 0) && (sel.addr == '0);

  // Next state of the write port, priority and drop counter.
  // wa/wd capture every transfer (including discarded ones) and hold otherwise;
  // wen is a single-cycle pulse per non-discarded transfer.
  always_comb begin
    wen_d  = 1'b0;
    wa_d   = wa_q;
    wd_d   = wd_q;
    prio_d = prio_q;
    drop_d = drop_q;
    if (xfer) begin
      wa_d   = sel.addr;
      wd_d   = sel.data;
      prio_d = ~gnt_idx;
      if (discard) begin
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end else begin
        wen_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q  <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
      prio_q <= 1'b0;
      drop_q <= '0;
    end else begin
      wen_q  <= wen_d;
      wa_q   <= wa_d;
      wd_q   <= wd_d;
      prio_q <= prio_d;
      drop_q <= drop_d;
    end
  end

  assign wen_o      = wen_q;
  assign wa_o       = wa_q;
  assign wd_o       = wd_q;
  assign prio_o     = prio_q;
  assign drop_cnt_o = drop_q;

endmodule
